// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: multi-cycle control unit for the MIPS core.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives
// the ALU operand selects, the ALU op, the register write enables and the
// instruction/data memory handshakes.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   instr[31:0]          current IR contents (opcode [31:26], funct [5:0])
//   zero                 ALU zero flag (qualifies beq)
//   imem_ready           instruction read data valid this cycle
//   dm_ready             data access complete this cycle
//   imem_req, dm_req     memory requests; dm_we marks a data write
//   ir_we, pc_we         IR / PC write enables
//   alu_out_we, rf_we    ALUOut / register file write enables
//   pc_sel[1:0]          0 ALU, 1 branch target, 2 jump target, 3 RS
//   alu_a_sel[2:0]       0 RS, 1 PC, 2 EXT5, 3 const 5 (unused), 7 none
//   alu_b_sel[2:0]       0 RT, 1 const 4, 2 sext imm, 3 zext imm, 4 imm<<16, 7 none
//   alu_op[3:0]          0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLL, 15 NOP
//   rf_wsel[1:0]         0 rd, 1 rt, 2 $31
//   rf_dsel[1:0]         0 ALUOut, 1 memory data, 2 PC
//   trap                 illegal instruction seen (held until reset)
//   state[2:0]           debug state code
module mcycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        imem_ready,
   input  logic        dm_ready,
   output logic        imem_req,
   output logic        dm_req,
   output logic        dm_we,
   output logic        ir_we,
   output logic        pc_we,
   output logic        alu_out_we,
   output logic        rf_we,
   output logic [1:0]  pc_sel,
   output logic [2:0]  alu_a_sel,
   output logic [2:0]  alu_b_sel,
   output logic [3:0]  alu_op,
   output logic [1:0]  rf_wsel,
   output logic [1:0]  rf_dsel,
   output logic        trap,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   state_t cur, nxt;

   logic [5:0] opcode, funct;
   logic is_addu, is_subu, is_and, is_or, is_sll, is_jr;
   logic is_addiu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
   logic is_rtype, legal;

   // write enables before reset gating
   logic ir_we_c, pc_we_c, alu_out_we_c, rf_we_c, dm_we_c;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];

   always_comb begin
      is_rtype = (opcode == 6'h00);
      is_addu  = is_rtype && (funct == 6'h21);
      is_subu  = is_rtype && (funct == 6'h23);
      is_and   = is_rtype && (funct == 6'h24);
      is_or    = is_rtype && (funct == 6'h25);
      is_sll   = is_rtype && (funct == 6'h00);
      is_jr    = is_rtype && (funct == 6'h08);
      is_addiu = (opcode == 6'h09);
      is_ori   = (opcode == 6'h0D);
      is_lui   = (opcode == 6'h0F);
      is_lw    = (opcode == 6'h23);
      is_sw    = (opcode == 6'h2B);
      is_beq   = (opcode == 6'h04);
      is_j     = (opcode == 6'h02);
      is_jal   = (opcode == 6'h03);
      legal    = is_addu | is_subu | is_and | is_or | is_sll | is_jr |
                 is_addiu | is_ori | is_lui | is_lw | is_sw |
                 is_beq | is_j | is_jal;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cur <= S_FETCH;
      else
         cur <= nxt;
   end

   always_comb begin
      nxt          = cur;
      imem_req     = 1'b0;
      dm_req       = 1'b0;
      dm_we_c      = 1'b0;
      ir_we_c      = 1'b0;
      pc_we_c      = 1'b0;
      alu_out_we_c = 1'b0;
      rf_we_c      = 1'b0;
      pc_sel       = 2'd0;
      alu_a_sel    = 3'd7;
      alu_b_sel    = 3'd7;
      alu_op       = 4'd15;
      rf_wsel      = 2'd0;
      rf_dsel      = 2'd0;
      trap         = 1'b0;

      unique case (cur)
         S_FETCH: begin
            imem_req  = 1'b1;
            alu_a_sel = 3'd1;
            alu_b_sel = 3'd1;
            alu_op    = 4'd0;
            if (imem_ready) begin
               ir_we_c = 1'b1;
               pc_we_c = 1'b1;
               nxt     = S_DECODE;
            end
         end

         S_DECODE: begin
            nxt = legal ? S_EXEC : S_TRAP;
         end

         S_EXEC: begin
            nxt = S_FETCH;
            if (is_addu | is_subu | is_and | is_or) begin
               alu_a_sel    = 3'd0;
               alu_b_sel    = 3'd0;
               alu_op       = is_subu ? 4'd1 : is_and ? 4'd2 : is_or ? 4'd3 : 4'd0;
               alu_out_we_c = 1'b1;
               nxt          = S_WB;
            end else if (is_sll) begin
               alu_a_sel    = 3'd2;
               alu_b_sel    = 3'd0;
               alu_op       = 4'd4;
               alu_out_we_c = 1'b1;
               nxt          = S_WB;
            end else if (is_addiu) begin
               alu_a_sel    = 3'd0;
               alu_b_sel    = 3'd2;
               alu_op       = 4'd0;
               alu_out_we_c = 1'b1;
               nxt          = S_WB;
            end else if (is_ori) begin
               alu_a_sel    = 3'd0;
               alu_b_sel    = 3'd3;
               alu_op       = 4'd3;
               alu_out_we_c = 1'b1;
               nxt          = S_WB;
            end else if (is_lui) begin
               // A left at "none" so the ALU sees 0 | (imm<<16)
               alu_b_sel    = 3'd4;
               alu_op       = 4'd3;
               alu_out_we_c = 1'b1;
               nxt          = S_WB;
            end else if (is_lw | is_sw) begin
               alu_a_sel    = 3'd0;
               alu_b_sel    = 3'd2;
               alu_op       = 4'd0;
               alu_out_we_c = 1'b1;
               nxt          = S_MEM;
            end else if (is_beq) begin
               alu_a_sel = 3'd0;
               alu_b_sel = 3'd0;
               alu_op    = 4'd1;
               if (zero) begin
                  pc_we_c = 1'b1;
                  pc_sel  = 2'd1;
               end
            end else if (is_j) begin
               pc_we_c = 1'b1;
               pc_sel  = 2'd2;
            end else if (is_jr) begin
               pc_we_c = 1'b1;
               pc_sel  = 2'd3;
            end else if (is_jal) begin
               // PC already holds PC+4, so the link value is taken from PC
               pc_we_c = 1'b1;
               pc_sel  = 2'd2;
               rf_we_c = 1'b1;
               rf_wsel = 2'd2;
               rf_dsel = 2'd2;
            end
         end

         S_MEM: begin
            dm_req  = 1'b1;
            dm_we_c = is_sw;
            if (dm_ready)
               nxt = is_sw ? S_FETCH : S_WB;
         end

         S_WB: begin
            rf_we_c = 1'b1;
            if (is_rtype) begin
               rf_wsel = 2'd0;
               rf_dsel = 2'd0;
            end else if (is_lw) begin
               rf_wsel = 2'd1;
               rf_dsel = 2'd1;
            end else begin
               rf_wsel = 2'd1;
               rf_dsel = 2'd0;
            end
            nxt = S_FETCH;
         end

         S_TRAP: begin
            trap = 1'b1;
         end

         default: begin
            nxt = S_FETCH;
         end
      endcase
   end

   // The state register already forces FETCH in reset; gating the
   // enables keeps the ready-qualified FETCH enables from pulsing.
   assign ir_we      = ir_we_c      & rst_n;
   assign pc_we      = pc_we_c      & rst_n;
   assign alu_out_we = alu_out_we_c & rst_n;
   assign rf_we      = rf_we_c      & rst_n;
   assign dm_we      = dm_we_c      & rst_n;
   assign state      = cur;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed testbench for mcycle_ctrl with hand-computed expected values.
module tb_mcycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        zero, imem_ready, dm_ready;
   logic        imem_req, dm_req, dm_we, ir_we, pc_we, alu_out_we, rf_we;
   logic [1:0]  pc_sel, rf_wsel, rf_dsel;
   logic [2:0]  alu_a_sel, alu_b_sel, state;
   logic [3:0]  alu_op;
   logic        trap;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   mcycle_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr      (instr),
      .zero       (zero),
      .imem_ready (imem_ready),
      .dm_ready   (dm_ready),
      .imem_req   (imem_req),
      .dm_req     (dm_req),
      .dm_we      (dm_we),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .alu_out_we (alu_out_we),
      .rf_we      (rf_we),
      .pc_sel     (pc_sel),
      .alu_a_sel  (alu_a_sel),
      .alu_b_sel  (alu_b_sel),
      .alu_op     (alu_op),
      .rf_wsel    (rf_wsel),
      .rf_dsel    (rf_dsel),
      .trap       (trap),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one clock; outputs sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {dm_we, ir_we, pc_we, alu_out_we, rf_we}
   function automatic logic [4:0] wes();
      return {dm_we, ir_we, pc_we, alu_out_we, rf_we};
   endfunction

   // load an instruction in FETCH (zero-wait) and step through DECODE to EXEC
   task automatic fetch_to_exec(input logic [31:0] ins, input string tag);
      imem_ready = 1'b1;
      instr      = ins;
      #1;
      check({tag, ".fetch_state"}, state, 0);
      check({tag, ".fetch_irwe"}, ir_we, 1);
      tick();
      imem_ready = 1'b0;
      check({tag, ".decode_state"}, state, 1);
      tick();
      check({tag, ".exec_state"}, state, 2);
   endtask

   initial begin
      rst_n = 1'b0; instr = 32'h0; zero = 1'b0; imem_ready = 1'b0; dm_ready = 1'b0;
      #3;
      // reset: FETCH Moore outputs, no enables even with imem_ready high
      check("rst.state", state, 0);
      check("rst.imem_req", imem_req, 1);
      check("rst.trap", trap, 0);
      check("rst.alu_sel", {alu_a_sel, alu_b_sel, alu_op}, {3'd1, 3'd1, 4'd0});
      imem_ready = 1'b1;
      #1;
      check("rst.wes", wes(), 5'b0);

      // addu $3,$1,$2 : 0,1,2,4,0
      instr = 32'h00221821;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("addu.c0", {state, ir_we, pc_we, 2'(pc_sel)}, {3'd0, 1'b1, 1'b1, 2'd0});
      tick();
      check("addu.c1", {state, wes()}, {3'd1, 5'b0});
      tick();
      check("addu.c2", {state, wes(), alu_a_sel, alu_b_sel, alu_op},
            {3'd2, 5'b00010, 3'd0, 3'd0, 4'd0});
      tick();
      check("addu.c3", {state, wes(), rf_wsel, rf_dsel}, {3'd4, 5'b00001, 2'd0, 2'd0});
      tick();
      check("addu.c4", state, 0);

      // fetch wait: imem_ready low holds FETCH
      imem_ready = 1'b0;
      #1;
      check("fwait.wes", wes(), 5'b0);
      tick();
      check("fwait.state", {state, imem_req}, {3'd0, 1'b1});

      // lw with 3 wait cycles
      fetch_to_exec(32'h8C220004, "lw");
      check("lw.exec", {wes(), alu_a_sel, alu_b_sel, alu_op}, {5'b00010, 3'd0, 3'd2, 4'd0});
      tick();
      for (int i = 0; i < 3; i++) begin
         check("lw.memwait", {state, dm_req, dm_we}, {3'd3, 1'b1, 1'b0});
         tick();
      end
      dm_ready = 1'b1;
      #1;
      check("lw.memdone", {state, dm_req, dm_we}, {3'd3, 1'b1, 1'b0});
      tick();
      dm_ready = 1'b0;
      check("lw.wb", {state, rf_we, rf_wsel, rf_dsel}, {3'd4, 1'b1, 2'd1, 2'd1});
      tick();
      check("lw.end", state, 0);

      // beq taken / not taken
      zero = 1'b1;
      fetch_to_exec(32'h10220003, "beq1");
      check("beq1.exec", {pc_we, pc_sel, alu_op}, {1'b1, 2'd1, 4'd1});
      tick();
      check("beq1.end", state, 0);
      zero = 1'b0;
      fetch_to_exec(32'h10220003, "beq0");
      check("beq0.exec", {wes(), alu_op}, {5'b0, 4'd1});
      tick();
      check("beq0.end", state, 0);

      // sll $2,$1,3
      fetch_to_exec(32'h000110C0, "sll");
      check("sll.exec", {alu_a_sel, alu_b_sel, alu_op, alu_out_we}, {3'd2, 3'd0, 4'd4, 1'b1});
      tick();
      check("sll.wb", {state, rf_we, rf_wsel}, {3'd4, 1'b1, 2'd0});
      tick();

      // ori: zext immediate, writes rt
      fetch_to_exec(32'h34220055, "ori");
      check("ori.exec", {alu_a_sel, alu_b_sel, alu_op}, {3'd0, 3'd3, 4'd3});
      tick();
      check("ori.wb", {rf_we, rf_wsel, rf_dsel}, {1'b1, 2'd1, 2'd0});
      tick();

      // lui: A none, B imm<<16, OR
      fetch_to_exec(32'h3C021234, "lui");
      check("lui.exec", {alu_a_sel, alu_b_sel, alu_op}, {3'd7, 3'd4, 4'd3});
      tick();
      tick();

      // jal: link and PC update together
      fetch_to_exec(32'h0C000010, "jal");
      check("jal.exec", {wes(), pc_sel, rf_wsel, rf_dsel},
            {5'b00101, 2'd2, 2'd2, 2'd2});
      tick();
      check("jal.end", state, 0);

      // jr
      fetch_to_exec(32'h03E00008, "jr");
      check("jr.exec", {wes(), pc_sel}, {5'b00100, 2'd3});
      tick();

      // illegal opcode 0x3F -> TRAP
      imem_ready = 1'b1;
      instr = 32'hFC000000;
      tick();
      check("ill.decode", state, 1);
      tick();
      for (int i = 0; i < 20; i++) begin
         check("ill.trap", {state, trap, imem_req, dm_req, wes()}, {3'd7, 1'b1, 1'b0, 1'b0, 5'b0});
         tick();
      end
      imem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("ill.rst", {state, trap}, {3'd0, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ill.rel", {state, trap}, {3'd0, 1'b0});

      // sw, reset asserted mid-MEM
      fetch_to_exec(32'hAC220008, "sw");
      tick();
      check("sw.mem", {state, dm_req, dm_we}, {3'd3, 1'b1, 1'b1});
      #2;
      rst_n = 1'b0;
      #1;
      check("sw.rst", {state, dm_req, dm_we, imem_req}, {3'd0, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("sw.rel", state, 0);

      // sw zero-wait completes straight to FETCH
      fetch_to_exec(32'hAC220008, "sw2");
      tick();
      dm_ready = 1'b1;
      #1;
      check("sw2.mem", {state, dm_req, dm_we}, {3'd3, 1'b1, 1'b1});
      tick();
      dm_ready = 1'b0;
      check("sw2.end", state, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mcycle_ctrl.md
# mcycle_ctrl

Multi-cycle control unit for the MIPS core. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. Every cycle it drives the select codes consumed by the ALU operand muxes, the ALU op, and all datapath write enables. It handshakes with instruction and data memory, and it is the sole source of the ALU-A select bus (codes RS=0, PC=1, EXT5=2, CONST5=3, NONE=7).

## Interface
- No parameters; all encodings below are fixed.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  current IR contents (opcode [31:26], funct [5:0])
- zero  in  1  ALU zero flag, combinational from the current ALU op
- imem_ready  in  1  instruction memory: read data valid this cycle
- dm_ready  in  1  data memory: access complete this cycle
- imem_req  out  1  instruction fetch request
- dm_req  out  1  data access request
- dm_we  out  1  data write (only with dm_req)
- ir_we, pc_we, alu_out_we, rf_we  out  1 each  register write enables
- pc_sel  out  2  PC source: 0 ALU, 1 branch target, 2 jump target, 3 RS
- alu_a_sel  out  3  ALU-A source: 0 RS, 1 PC, 2 EXT5 (shamt), 3 constant 5, 7 none
- alu_b_sel  out  3  ALU-B source: 0 RT, 1 constant 4, 2 sign-ext imm16, 3 zero-ext imm16, 4 imm16<<16, 7 none
- alu_op  out  4  0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLL, 15 NOP
- rf_wsel  out  2  destination: 0 rd, 1 rt, 2 $31
- rf_dsel  out  2  write data source: 0 ALUOut, 1 memory data, 2 PC
- trap  out  1  illegal instruction seen; sticky
- state  out  3  debug: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 TRAP

## Operation
- Supported opcodes:
  - R-type (op 0) with funct addu 0x21, subu 0x23, and 0x24, or 0x25, sll 0x00, jr 0x08
  - addiu 0x09, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03
  - Anything else is illegal.
- Idle defaults, all states unless overridden: all enables 0, alu_a_sel=7, alu_b_sel=7, alu_op=15, pc_sel=0, rf_wsel=0, rf_dsel=0.
- FETCH:
  - imem_req=1, alu_a_sel=1, alu_b_sel=1, alu_op=0.
  - While imem_ready=0, hold FETCH.
  - On the imem_ready cycle: ir_we=1, pc_we=1 (pc_sel=0, i.e. PC+4), then go to DECODE.
- DECODE: one cycle, no enables. Illegal instruction → TRAP; otherwise → EXEC.
- EXEC, by instruction:
  - ALU R-ops: A=0, B=0, op per funct; sll uses A=2, B=0, op=4. alu_out_we=1 → WB.
  - addiu: A=0, B=2, op=0. ori: A=0, B=3, op=3. lui: A=7, B=4, op=3 (A treated as 0). alu_out_we=1 → WB.
  - lw/sw: A=0, B=2, op=0, alu_out_we=1 → MEM.
  - beq: A=0, B=1… correction: A=0, B=0, op=1. If zero=1: pc_we=1, pc_sel=1. → FETCH.
  - j: pc_we=1, pc_sel=2 → FETCH.
  - jr: pc_we=1, pc_sel=3 → FETCH.
  - jal: pc_we=1, pc_sel=2, rf_we=1, rf_wsel=2, rf_dsel=2 (PC already +4) → FETCH.
- MEM:
  - dm_req=1; dm_we=1 for sw.
  - Hold while dm_ready=0.
  - On dm_ready: sw → FETCH; lw → WB.
- WB:
  - rf_we=1 for one cycle.
  - R-type: rf_wsel=0, rf_dsel=0. I-type ALU: rf_wsel=1, rf_dsel=0. lw: rf_wsel=1, rf_dsel=1.
  - → FETCH.
- TRAP: trap=1, all enables 0; exit only by reset.
- alu_a_sel code 3 is never emitted.
- Decode uses instr; the IR is stable from DECODE onward.

## Timing
- Reset (rst_n low, asynchronous): state=FETCH and trap=0. All outputs take their FETCH-state Moore values immediately, so imem_req=1 in reset.
- Outputs are combinational from the state register and instr. The exceptions are the imem_ready/dm_ready/zero-qualified enables, which are combinational on those inputs within the cycle.
- Cycle counts with zero-wait memory:
  - R/I ALU: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/j/jr/jal: 3 cycles
- Each memory wait cycle adds 1.
- A ready signal asserted outside the matching state is ignored.
- Reset mid-MEM drops dm_req asynchronously. No write enable may pulse during reset.
- A write to $31 by jal and the PC update occur on the same edge.

## Test plan
- Reset release with imem_ready=1, instr=addu $3,$1,$2 (0x00221821) → state sequence 0,1,2,4,0; ir_we/pc_we on cycle 0; alu_out_we on cycle 2; rf_we=1 with rf_wsel=0 on cycle 3.
- lw (0x8C220004) with dm_ready held low 3 cycles → dm_req=1 for 4 cycles with dm_we=0, then WB with rf_dsel=1, rf_wsel=1.
- beq with zero=1 → pc_we=1, pc_sel=1 in EXEC; repeat with zero=0 → pc_we=0; both return to FETCH.
- sll $2,$1,3 (0x000110C0) → EXEC alu_a_sel=2, alu_op=4; jal → rf_we, rf_wsel=2, rf_dsel=2, pc_sel=2 on the same cycle.
- Illegal opcode 0x3F → TRAP after DECODE; trap=1 and all enables stay 0 for 20 cycles; rst_n pulse → FETCH, trap=0.
- rst_n asserted mid-MEM of sw → dm_req and dm_we drop the same cycle; state=0 after release.
